// File: rtl/weight_seq_ctrl_if.sv
// Handshake and memory/MAC bus of one neuron's weight sequencer.
// The controller connects through the slave modport. The surrounding
// layer logic, weight memory and MAC connect through the master modport.
interface weight_seq_ctrl_if #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) ();
    // Configuration stream (weight load)
    logic                    cfg_start;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [dataWidth-1:0]    cfg_data;

    // Input sample stream
    logic                    x_valid;
    logic                    x_ready;
    logic [dataWidth-1:0]    x_in;

    // Weight memory ports
    logic                    mem_wen;
    logic [addressWidth-1:0] mem_wadd;
    logic [dataWidth-1:0]    mem_win;
    logic                    mem_ren;
    logic [addressWidth-1:0] mem_radd;
    logic [dataWidth-1:0]    mem_wout;

    // Aligned pairs to the MAC
    logic                    mac_valid;
    logic [dataWidth-1:0]    mac_x;
    logic [dataWidth-1:0]    mac_w;
    logic                    mac_first;
    logic                    mac_last;

    // Status
    logic                    loaded;
    logic                    load_done;
    logic                    busy;

    // Environment side: layer distribution, weight memory, MAC
    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_ready,
        output x_valid, x_in,
        input  x_ready,
        input  mem_wen, mem_wadd, mem_win, mem_ren, mem_radd,
        output mem_wout,
        input  mac_valid, mac_x, mac_w, mac_first, mac_last,
        input  loaded, load_done, busy
    );

    // Controller side
    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_ready,
        input  x_valid, x_in,
        output x_ready,
        output mem_wen, mem_wadd, mem_win, mem_ren, mem_radd,
        input  mem_wout,
        output mac_valid, mac_x, mac_w, mac_first, mac_last,
        output loaded, load_done, busy
    );
endinterface

// File: rtl/weight_seq_ctrl.sv
// Per-neuron weight sequencer.
// LOAD streams configuration words into consecutive weight addresses.
// RUN issues one read per accepted input sample. Each sample is paired
// with the weight returned by the 1-cycle registered memory read, and the
// pair is presented to the MAC one cycle after acceptance, together with
// first/last markers.
module weight_seq_ctrl #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic               clk,
    input  logic               rst,
    weight_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
    localparam logic [addressWidth-1:0] ONE      = addressWidth'(1);

    state_t                  state, state_nxt;
    logic [addressWidth-1:0] wcnt, wcnt_nxt;
    logic [addressWidth-1:0] rcnt, rcnt_nxt;
    logic                    loaded_r, loaded_nxt;
    logic                    load_done_r, load_done_nxt;

    // Handshake decode
    logic                    cfg_rdy;
    logic                    x_rdy;
    logic                    cfg_fire;

    // Stage p0: accepted sample and its pair index
    logic                    vld_p0;
    logic [addressWidth-1:0] idx_p0;

    // Stage p1: registered sample aligned with the memory read data
    logic                    vld_p1;
    logic signed [dataWidth-1:0] x_p1;
    logic                    first_p1;
    logic                    last_p1;

    // Handshake readiness. cfg_start wins over a sample offered in IDLE.
    always_comb begin
        cfg_rdy  = (state == LOAD);
        x_rdy    = loaded_r && (((state == IDLE) && !bus.cfg_start) || (state == RUN));
        cfg_fire = bus.cfg_valid && cfg_rdy;
        vld_p0   = bus.x_valid && x_rdy;
        idx_p0   = (state == IDLE) ? '0 : rcnt;
    end

    // Memory port drive. Writes only happen in LOAD and reads only in
    // IDLE/RUN, so the two enables can never be asserted together.
    always_comb begin
        bus.cfg_ready = cfg_rdy;
        bus.x_ready   = x_rdy;
        bus.mem_wen   = cfg_fire;
        bus.mem_wadd  = cfg_fire ? wcnt : '0;
        bus.mem_win   = cfg_fire ? bus.cfg_data : '0;
        bus.mem_ren   = vld_p0;
        bus.mem_radd  = vld_p0 ? idx_p0 : '0;
    end

    // Next-state logic for the load/run sequencer
    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        rcnt_nxt      = rcnt;
        loaded_nxt    = loaded_r;
        load_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_nxt  = LOAD;
                    wcnt_nxt   = '0;
                    loaded_nxt = 1'b0;
                end else if (vld_p0) begin
                    if (numWeight == 1) begin
                        state_nxt = DRAIN;
                        rcnt_nxt  = '0;
                    end else begin
                        state_nxt = RUN;
                        rcnt_nxt  = ONE;
                    end
                end
            end
            LOAD: begin
                if (cfg_fire) begin
                    if (wcnt == LAST_IDX) begin
                        state_nxt     = IDLE;
                        wcnt_nxt      = '0;
                        loaded_nxt    = 1'b1;
                        load_done_nxt = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt + ONE;
                    end
                end
            end
            RUN: begin
                if (vld_p0) begin
                    if (rcnt == LAST_IDX) begin
                        state_nxt = DRAIN;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + ONE;
                    end
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state, counters and load status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            rcnt        <= '0;
            loaded_r    <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            rcnt        <= rcnt_nxt;
            loaded_r    <= loaded_nxt;
            load_done_r <= load_done_nxt;
        end
    end

    // ---- stage p0 -> p1: hold the sample while the weight is read ----
    // Data is cleared on reset as well, so every output reads zero in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            x_p1     <= '0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            x_p1     <= vld_p0 ? bus.x_in : '0;
            first_p1 <= vld_p0 && (idx_p0 == '0);
            last_p1  <= vld_p0 && (idx_p0 == LAST_IDX);
        end
    end

    // ---- stage p1: pair presented to the MAC ----
    // The memory already returns zero when not read; gating on vld_p1 keeps
    // mac_w clean in reset regardless of the memory's own reset behaviour.
    always_comb begin
        bus.mac_valid = vld_p1;
        bus.mac_x     = x_p1;
        bus.mac_w     = vld_p1 ? bus.mem_wout : '0;
        bus.mac_first = first_p1;
        bus.mac_last  = last_p1;
        bus.loaded    = loaded_r;
        bus.load_done = load_done_r;
        bus.busy      = (state != IDLE) || vld_p1;
    end

    // The single-port memory cannot take a write and a read in one cycle
    assert property (@(posedge clk) disable iff (rst) !(bus.mem_wen && bus.mem_ren));

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Bench for weight_seq_ctrl with numWeight=3. A behavioural weight memory
// sits on the memory ports. Expected MAC pairs are queued at acceptance
// time and retired by a monitor when mac_valid appears.
module tb_weight_seq_ctrl;

    localparam int NW = 3;
    localparam int AW = 10;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        logic          f;
        logic          l;
        int            due;
    } pair_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;
    pair_t sb[$];
    logic [DW-1:0] cur_w [NW];
    logic [DW-1:0] wmem [0:(1<<AW)-1];

    weight_seq_ctrl_if #(.addressWidth(AW), .dataWidth(DW)) bus ();

    weight_seq_ctrl #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural weight memory: 1-cycle registered read, zero when not read
    always @(posedge clk) begin
        if (bus.mem_wen) wmem[bus.mem_wadd] <= bus.mem_win;
        bus.mem_wout <= bus.mem_ren ? wmem[bus.mem_radd] : '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Retire expected pairs as the DUT presents them
    always @(negedge clk) begin
        if (!rst && bus.mac_valid) begin
            if (sb.size() == 0) begin
                check_eq("mac_unexpected", 32'd1, 32'd0);
            end else begin
                pair_t e;
                e = sb.pop_front();
                check_eq("mac_x", bus.mac_x, e.x);
                check_eq("mac_w", bus.mac_w, e.w);
                check_eq("mac_first", bus.mac_first, e.f);
                check_eq("mac_last", bus.mac_last, e.l);
                check_eq("mac_latency", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic cs, input logic cv, input logic [DW-1:0] cd,
                         input logic xv, input logic [DW-1:0] xi);
        bus.cfg_start = cs;
        bus.cfg_valid = cv;
        bus.cfg_data  = cd;
        bus.x_valid   = xv;
        bus.x_in      = xi;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cfg_ready"}, bus.cfg_ready, 0);
        check_eq({tag, "_x_ready"},   bus.x_ready, 0);
        check_eq({tag, "_mem_wen"},   bus.mem_wen, 0);
        check_eq({tag, "_mem_wadd"},  bus.mem_wadd, 0);
        check_eq({tag, "_mem_win"},   bus.mem_win, 0);
        check_eq({tag, "_mem_ren"},   bus.mem_ren, 0);
        check_eq({tag, "_mem_radd"},  bus.mem_radd, 0);
        check_eq({tag, "_mac_valid"}, bus.mac_valid, 0);
        check_eq({tag, "_mac_x"},     bus.mac_x, 0);
        check_eq({tag, "_mac_w"},     bus.mac_w, 0);
        check_eq({tag, "_mac_first"}, bus.mac_first, 0);
        check_eq({tag, "_mac_last"},  bus.mac_last, 0);
        check_eq({tag, "_loaded"},    bus.loaded, 0);
        check_eq({tag, "_load_done"}, bus.load_done, 0);
        check_eq({tag, "_busy"},      bus.busy, 0);
    endtask

    // Full weight load; with_x keeps a competing sample offered throughout
    task automatic do_load(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input logic with_x);
        logic [DW-1:0] w [NW];
        w[0] = w0; w[1] = w1; w[2] = w2;
        tick(); drive(1'b1, 1'b0, '0, with_x, 16'hdead); sample();
        check_eq("ld_start_x_ready", bus.x_ready, 0);
        check_eq("ld_start_mem_ren", bus.mem_ren, 0);
        for (int i = 0; i < NW; i++) begin
            tick(); drive(1'b0, 1'b1, w[i], with_x, 16'hdead); sample();
            check_eq("ld_cfg_ready", bus.cfg_ready, 1);
            check_eq("ld_mem_wen", bus.mem_wen, 1);
            check_eq("ld_mem_wadd", bus.mem_wadd, i);
            check_eq("ld_mem_win", bus.mem_win, w[i]);
            check_eq("ld_mem_ren", bus.mem_ren, 0);
            check_eq("ld_x_ready", bus.x_ready, 0);
            check_eq("ld_loaded_low", bus.loaded, 0);
            check_eq("ld_done_early", bus.load_done, 0);
        end
        tick(); drive(1'b0, 1'b0, '0, 1'b0, '0); sample();
        check_eq("ld_done_pulse", bus.load_done, 1);
        check_eq("ld_loaded", bus.loaded, 1);
        check_eq("ld_wen_after", bus.mem_wen, 0);
        for (int i = 0; i < NW; i++) cur_w[i] = w[i];
        tick(); sample();
        check_eq("ld_done_clear", bus.load_done, 0);
        check_eq("ld_idle_busy", bus.busy, 0);
    endtask

    // One input vector; gap idle cycles inserted between index 0 and 1
    task automatic run_vec(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                           input logic [DW-1:0] x2, input int gap);
        logic [DW-1:0] x [NW];
        pair_t p;
        x[0] = x0; x[1] = x1; x[2] = x2;
        for (int i = 0; i < NW; i++) begin
            if (i == 1) begin
                for (int k = 0; k < gap; k++) begin
                    tick(); drive(1'b0, 1'b0, '0, 1'b0, 16'h5a5a); sample();
                    check_eq("gap_mem_ren", bus.mem_ren, 0);
                    check_eq("gap_busy", bus.busy, 1);
                    if (k > 0) check_eq("gap_mac_valid", bus.mac_valid, 0);
                end
            end
            tick(); drive(1'b0, 1'b0, '0, 1'b1, x[i]); sample();
            check_eq("run_x_ready", bus.x_ready, 1);
            check_eq("run_mem_ren", bus.mem_ren, 1);
            check_eq("run_mem_radd", bus.mem_radd, i);
            check_eq("run_mem_wen", bus.mem_wen, 0);
            p.x = x[i]; p.w = cur_w[i]; p.f = (i == 0); p.l = (i == NW - 1); p.due = cyc + 1;
            sb.push_back(p);
        end
        // DRAIN: a sample offered here must be refused
        tick(); drive(1'b0, 1'b0, '0, 1'b1, 16'hbeef); sample();
        check_eq("drain_x_ready", bus.x_ready, 0);
        check_eq("drain_mem_ren", bus.mem_ren, 0);
        check_eq("drain_busy", bus.busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        sample();
        check_all_zero("rst");
        tick(); rst = 1'b0;

        // Samples offered before any load are ignored
        for (int i = 0; i < 5; i++) begin
            tick(); drive(1'b0, 1'b0, '0, 1'b1, 16'h0100 + 16'(i)); sample();
            check_eq("noload_x_ready", bus.x_ready, 0);
            check_eq("noload_mem_ren", bus.mem_ren, 0);
            check_eq("noload_mac_valid", bus.mac_valid, 0);
        end

        do_load(16'h0011, 16'h0022, 16'h0033, 1'b0);

        // Back-to-back vectors, the second one with a 2-cycle gap
        run_vec(16'h0100, 16'h0200, 16'h0300, 0);
        run_vec(16'h0100, 16'h0200, 16'h0300, 2);
        tick(); drive(1'b0, 1'b0, '0, 1'b0, '0); sample();
        check_eq("post_run_busy", bus.busy, 0);
        check_eq("post_run_mac_valid", bus.mac_valid, 0);

        // cfg_start wins over a concurrent sample; reload while offered
        do_load(16'h0a0a, 16'h0b0b, 16'h0c0c, 1'b1);
        run_vec(16'h8001, 16'h7fff, 16'hffff, 0);

        // Reset in the middle of a load abandons it
        tick(); drive(1'b1, 1'b0, '0, 1'b0, '0); sample();
        tick(); drive(1'b0, 1'b1, 16'h1234, 1'b0, '0); sample();
        tick(); drive(1'b0, 1'b1, 16'h5678, 1'b0, '0); sample();
        tick(); drive(1'b0, 1'b1, 16'h9abc, 1'b1, 16'h0777);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b0, 1'b0, '0, 1'b1, 16'h0777); sample();
            check_eq("postrst_x_ready", bus.x_ready, 0);
            check_eq("postrst_mem_ren", bus.mem_ren, 0);
            check_eq("postrst_loaded", bus.loaded, 0);
        end
        do_load(16'h1111, 16'h2222, 16'h3333, 1'b0);
        run_vec(16'h0004, 16'h0005, 16'h0006, 1);

        repeat (3) begin tick(); drive(1'b0, 1'b0, '0, 1'b0, '0); end
        sample();
        check_eq("sb_empty", sb.size(), 0);
        check_eq("final_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
